rr_prio_arbiter: RTL

Parametrised, registered round-robin priority arbiter that generalises the team's 8-to-3 fixed-MSB priority encoder to N requesters with rotating priority and a valid/ready grant handshake. It sits between a bank of request lines and a shared resource. Each accepted grant demotes the winner to lowest priority, so the arbiter is starvation-free. Out of reset it behaves like the 8:3 encoder: the highest set index wins.

---
 rtl/rr_prio_arbiter.sv | 178 +++++++++++++++++
 1 files changed

// File: rtl/rr_prio_arbiter.sv
// -----------------------------------------------------------------------------
// rr_prio_arbiter
//
// Registered round-robin priority arbiter with a valid/ready grant handshake.
// N requesters compete for one shared resource. The pointer marks the index
// with the highest priority. The search runs downward from the pointer and
// wraps from 0 to N-1. Each accepted grant moves the pointer to just below the
// winner, so the winner becomes lowest priority and no requester starves.
// Out of reset the pointer is N-1, so the arbiter first behaves like a fixed
// MSB-first priority encoder.
//
// Optional feature macro: RR_ARB_LOCK_EN
//   When defined, a `lock` input exists. An accept with lock=1 holds the
//   current grant (same index, pointer unchanged) for multi-beat bursts.
//
// Ports:
//   clk        in   1     rising-edge clock
//   rst_n      in   1     asynchronous active-low reset
//   req        in   N     request vector, bit i = requester i
//   gnt_ready  in   1     consumer accepts the presented grant
//   lock       in   1     (RR_ARB_LOCK_EN only) keep grant across accept
//   gnt_valid  out  1     grant presented
//   gnt_idx    out  IDXW  binary index of the granted requester (0 when idle)
//   gnt_onehot out  N     one-hot form of gnt_idx (0 when idle)
// -----------------------------------------------------------------------------
module rr_prio_arbiter #(
  parameter  int N    = 8,
  localparam int IDXW = (N > 1) ? $clog2(N) : 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [N-1:0]    req,
  input  logic            gnt_ready,
`ifdef RR_ARB_LOCK_EN
  input  logic            lock,
`endif
  output logic            gnt_valid,
  output logic [IDXW-1:0] gnt_idx,
  output logic [N-1:0]    gnt_onehot
);

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } state_e;

  localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
  localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);
  localparam logic [IDXW-1:0] IDX_LAST = IDXW'(N - 1);
  localparam logic [N-1:0]    VEC_ZERO = {N{1'b0}};

  // Search order ptr, ptr-1, ..., 0, N-1, ..., ptr+1. The modulo keeps the
  // wrap inside 0..N-1 even when N is not a power of two.
  // Returns {found, winner_index}.
  function automatic logic [IDXW:0] arbitrate(input logic [N-1:0] r,
                                               input logic [IDXW-1:0] p);
    logic            found;
    logic            hit;
    logic [IDXW-1:0] win;
    logic [IDXW-1:0] cand;
    int              j;
    found = 1'b0;
    win   = IDX_ZERO;
    for (int k = 0; k < N; k++) begin
      j     = (int'(p) - k + N) % N;
      cand  = j[IDXW-1:0];
      hit   = r[cand] & ~found;
      win   = hit ? cand : win;
      found = found | r[cand];
    end
    return {found, win};
  endfunction

  function automatic logic [N-1:0] to_onehot(input logic [IDXW-1:0] idx);
    logic [N-1:0] base;
    base = {{(N-1){1'b0}}, 1'b1};
    return base << idx;
  endfunction

  state_e          state_q, state_d;
  logic [IDXW-1:0] ptr_q, ptr_d;
  logic            gnt_valid_q, gnt_valid_d;
  logic [IDXW-1:0] gnt_idx_q, gnt_idx_d;
  logic [N-1:0]    gnt_onehot_q, gnt_onehot_d;

  logic            lock_s;
  logic [IDXW-1:0] ptr_next_s;
  logic [IDXW:0]   arb_idle_s;
  logic [IDXW:0]   arb_acc_s;

`ifdef RR_ARB_LOCK_EN
  assign lock_s = lock;
`else
  assign lock_s = 1'b0;
`endif

  // Next-state, pointer and registered-output computation.
  always_comb begin
    state_d      = state_q;
    ptr_d        = ptr_q;
    gnt_valid_d  = gnt_valid_q;
    gnt_idx_d    = gnt_idx_q;
    gnt_onehot_d = gnt_onehot_q;

    // Pointer after accepting the current winner: one below it, 0 wraps to N-1.
    ptr_next_s = (gnt_idx_q == IDX_ZERO) ? IDX_LAST : (gnt_idx_q - IDX_ONE);
    arb_idle_s = arbitrate(req, ptr_q);
    // Re-arbitration on accept uses the updated pointer so there is no bubble.
    arb_acc_s  = arbitrate(req, ptr_next_s);

    case (state_q)
      IDLE: begin
        if (arb_idle_s[IDXW]) begin
          state_d      = GRANT;
          gnt_valid_d  = 1'b1;
          gnt_idx_d    = arb_idle_s[IDXW-1:0];
          gnt_onehot_d = to_onehot(arb_idle_s[IDXW-1:0]);
        end else begin
          state_d      = IDLE;
          gnt_valid_d  = 1'b0;
          gnt_idx_d    = IDX_ZERO;
          gnt_onehot_d = VEC_ZERO;
        end
      end
      GRANT: begin
        if (gnt_ready && !lock_s) begin
          ptr_d = ptr_next_s;
          if (arb_acc_s[IDXW]) begin
            state_d      = GRANT;
            gnt_valid_d  = 1'b1;
            gnt_idx_d    = arb_acc_s[IDXW-1:0];
            gnt_onehot_d = to_onehot(arb_acc_s[IDXW-1:0]);
          end else begin
            state_d      = IDLE;
            gnt_valid_d  = 1'b0;
            gnt_idx_d    = IDX_ZERO;
            gnt_onehot_d = VEC_ZERO;
          end
        end else begin
          // Stalled or locked: grant is sticky, req is ignored.
          state_d      = GRANT;
          gnt_valid_d  = gnt_valid_q;
          gnt_idx_d    = gnt_idx_q;
          gnt_onehot_d = gnt_onehot_q;
        end
      end
      default: begin
        state_d      = IDLE;
        ptr_d        = IDX_LAST;
        gnt_valid_d  = 1'b0;
        gnt_idx_d    = IDX_ZERO;
        gnt_onehot_d = VEC_ZERO;
      end
    endcase
  end

  // FSM state, pointer and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      ptr_q        <= IDX_LAST;
      gnt_valid_q  <= 1'b0;
      gnt_idx_q    <= IDX_ZERO;
      gnt_onehot_q <= VEC_ZERO;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      gnt_valid_q  <= gnt_valid_d;
      gnt_idx_q    <= gnt_idx_d;
      gnt_onehot_q <= gnt_onehot_d;
    end
  end

  assign gnt_valid  = gnt_valid_q;
  assign gnt_idx    = gnt_idx_q;
  assign gnt_onehot = gnt_onehot_q;

endmodule
